// File: rtl/approx_mult_sched.sv
// Round-robin scheduler sharing one combinational approximate multiplier
// among NREQ requesters; one operation in flight at a time.
module approx_mult_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*W-1:0]    req_a,
    input  logic [NREQ*W-1:0]    req_b,
    output logic [W-1:0]         mul_a,
    output logic [W-1:0]         mul_b,
    input  logic [2*W-1:0]       mul_c,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [2*W-1:0]       rsp_data,
    output logic                 busy
);

    localparam int unsigned PW = 2 * W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IDW-1:0]  last_q;
    logic [IDW-1:0]  grant_idx_c;
    logic            grant_any_c;
    logic            xfer_c;
    logic [W-1:0]    sel_a_c;
    logic [W-1:0]    sel_b_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Round-robin search starting after the last winner, plus next-state logic
    always_comb begin
        logic [IDW-1:0] cand;
        cand        = '0;
        grant_idx_c = '0;
        grant_any_c = 1'b0;
        req_ready   = '0;
        xfer_c      = 1'b0;
        state_d     = state_q;

        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(last_q) + k) % NREQ);
            if (!grant_any_c && req_valid[cand]) begin
                grant_any_c = 1'b1;
                grant_idx_c = cand;
            end
        end

        case (state_q)
            IDLE: begin
                if (grant_any_c) begin
                    req_ready[grant_idx_c] = 1'b1;
                    xfer_c                 = 1'b1;
                    state_d                = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand mux for the winning requester
    always_comb begin
        sel_a_c = '0;
        sel_b_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_idx_c == IDW'(i)) begin
                sel_a_c = req_a[i*W +: W];
                sel_b_c = req_b[i*W +: W];
            end
        end
    end

    // Operand/index capture on transfer; product capture in EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a    <= '0;
            mul_b    <= '0;
            rsp_id   <= '0;
            last_q   <= IDW'(NREQ - 1);
            rsp_data <= '0;
        end else begin
            if (xfer_c) begin
                mul_a  <= sel_a_c;
                mul_b  <= sel_b_c;
                rsp_id <= grant_idx_c;
                last_q <= grant_idx_c;
            end
            // Log-domain approximation is undefined at zero, so force the result
            if (state_q == EXEC) begin
                if ((mul_a == '0) || (mul_b == '0)) begin
                    rsp_data <= PW'(0);
                end else begin
                    rsp_data <= mul_c;
                end
            end
        end
    end

    // Registered status flags decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= (state_d == RESP);
            busy      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_approx_mult_sched.sv
// Directed testbench for approx_mult_sched with a stand-in multiplier.
module tb_approx_mult_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned IDW  = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*W-1:0]    req_a;
    logic [NREQ*W-1:0]    req_b;
    logic [W-1:0]         mul_a;
    logic [W-1:0]         mul_b;
    logic [2*W-1:0]       mul_c;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [2*W-1:0]       rsp_data;
    logic                 busy;

    int checks;
    int failures;

    // Stand-in multiplier: exact product, garbage on a zero operand like the
    // real log-domain unit, so a missing zero short-circuit shows up.
    assign mul_c = ((mul_a == '0) || (mul_b == '0)) ? 16'hDEAD
                 : 16'(mul_a) * 16'(mul_b);

    approx_mult_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_c     (mul_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b);
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy} !== '0) begin
            failures++;
            $display("FAIL reset_values: ready=%b a=%h b=%h v=%b id=%0d d=%h busy=%b, want all zero",
                     req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_idle: busy=%b v=%b ready=%b, want 0 0 0000", busy, rsp_valid, req_ready);
        end
    endtask

    task automatic test_single();
        set_req(1, 8'h29, 8'h10);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL single_grant: ready=%b want 0010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (mul_a !== 8'h29 || mul_b !== 8'h10 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_exec: a=%h b=%h busy=%b v=%b want 29 10 1 0", mul_a, mul_b, busy, rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 16'h0290) begin
            failures++;
            $display("FAIL single_rsp: v=%b id=%0d d=%h want 1 1 0290", rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || mul_a !== 8'h29) begin
            failures++;
            $display("FAIL single_done: v=%b busy=%b a=%h want 0 0 29", rsp_valid, busy, mul_a);
        end
    endtask

    task automatic test_zero();
        set_req(2, 8'h00, 8'hFF);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL zero_grant: ready=%b want 0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 16'h0000) begin
            failures++;
            $display("FAIL zero_rsp: v=%b id=%0d d=%h want 1 2 0000", rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ready;
        int         g;
        apply_reset();
        for (int r = 0; r < 4; r++) set_req(r, 8'(r + 1), 8'h10);
        req_valid = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            #1;
            g = (c / 3) % 4;
            exp_ready = (c % 3 == 0) ? (4'b0001 << g) : 4'b0000;
            checks++;
            if (req_ready !== exp_ready) begin
                failures++;
                $display("FAIL rr_grant c=%0d: ready=%b want %b", c, req_ready, exp_ready);
            end
            if (c % 3 == 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_data !== 16'((g + 1) * 16)) begin
                    failures++;
                    $display("FAIL rr_rsp c=%0d: v=%b id=%0d d=%h want 1 %0d %h",
                             c, rsp_valid, rsp_id, rsp_data, g, 16'((g + 1) * 16));
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        // Pointer is at 0 here, so requester 3 alone wins
        set_req(3, 8'h80, 8'h02);
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL bp_grant: ready=%b want 1000", req_ready);
        end
        @(negedge clk);
        set_req(0, 8'h03, 8'h04);
        req_valid = 4'b0001;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 16'h0100 || req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL bp_hold k=%0d: v=%b id=%0d d=%h ready=%b want 1 3 0100 0000",
                         k, rsp_valid, rsp_id, rsp_data, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL bp_accept: v=%b ready=%b want 1 0000", rsp_valid, req_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_next_grant: ready=%b v=%b want 0001 0", req_ready, rsp_valid);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int t;
        set_req(2, 8'h05, 8'h07);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL mid_grant: ready=%b want 0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        checks++;
        if ({req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy} !== '0) begin
            failures++;
            $display("FAIL mid_reset_values: ready=%b a=%h b=%h v=%b id=%0d d=%h busy=%b, want all zero",
                     req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL mid_no_rsp k=%0d: v=%b busy=%b want 0 0", k, rsp_valid, busy);
            end
        end
        set_req(3, 8'h09, 8'h09);
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL mid_first_grant: ready=%b want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        t = 0;
        while (rsp_valid !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'h000C) begin
            failures++;
            $display("FAIL mid_after_rsp: v=%b id=%0d d=%h want 1 0 000c", rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_sweep();
        logic [7:0]  va [7];
        logic [7:0]  vb [7];
        logic [15:0] vp [7];
        int          r;
        int          t;
        va = '{8'h29, 8'hFF, 8'h01, 8'h80, 8'h00, 8'h33, 8'hFF};
        vb = '{8'h10, 8'h01, 8'hFF, 8'h80, 8'h00, 8'h00, 8'hFF};
        vp = '{16'h0290, 16'h00FF, 16'h00FF, 16'h4000, 16'h0000, 16'h0000, 16'hFE01};
        for (int v = 0; v < 7; v++) begin
            r = v % 4;
            set_req(r, va[v], vb[v]);
            req_valid = 4'b0001 << r;
            #1;
            checks++;
            if (req_ready !== (4'b0001 << r)) begin
                failures++;
                $display("FAIL sweep_grant v=%0d: ready=%b want %b", v, req_ready, 4'b0001 << r);
            end
            @(negedge clk);
            req_valid = '0;
            t = 0;
            while (rsp_valid !== 1'b1 && t < 10) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(r) || rsp_data !== vp[v]) begin
                failures++;
                $display("FAIL sweep_rsp v=%0d: v=%b id=%0d d=%h want 1 %0d %h",
                         v, rsp_valid, rsp_id, rsp_data, r, vp[v]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_zero();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/approx_mult_sched.md
# approx_mult_sched

Round-robin scheduler that shares one combinational 8x8 Mitchell-based approximate multiplier (`ApproxModule`, ports `a`, `b`, `c`) among `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and registers the operands into the multiplier. It captures the 16-bit product one cycle later and returns it, tagged with the requester index, over a single valid/ready response port. It sits between the processing-element front ends and the shared multiplier instance, and is the only driver of the multiplier inputs.

## Interface
- `NREQ`, 4: number of requesters; 2..8.
- `W`, 8: operand width; product width is `2*W`.
- `IDW`, 2: requester-index width, `clog2(NREQ)`.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  requester i has an operand pair.
- `req_ready`  out  NREQ  one-hot grant; transfer on `req_valid[i] & req_ready[i]`.
- `req_a`  in  NREQ*W  operand a, requester i at bits `[i*W +: W]`.
- `req_b`  in  NREQ*W  operand b, same packing.
- `mul_a`  out  W  registered operand to multiplier `a`.
- `mul_b`  out  W  registered operand to multiplier `b`.
- `mul_c`  in  2W  multiplier product `c` (combinational from `mul_a`/`mul_b`).
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  IDW  index of requester that issued the operands.
- `rsp_data`  out  2W  product.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: the grant is computed combinationally from `req_valid` and the priority pointer `last`.
  - Search order is `last+1, last+2, …`, wrapping modulo NREQ.
  - `req_ready` is one-hot on the first valid requester found; all zeros if none are valid.
  - On a transfer: latch `req_a`/`req_b` of the winner into `mul_a`/`mul_b`, latch the winner index into `id_q`, set `last` to the winner, go to EXEC.
- EXEC (exactly one cycle): capture `mul_c` into `rsp_data`, unless a zero operand was latched.
  - Zero short-circuit: if `mul_a==0` or `mul_b==0`, load `rsp_data=0` instead of `mul_c`. The multiplier's log approximation is undefined at zero.
  - Go to RESP.
- RESP: `rsp_valid=1`, `rsp_id=id_q`. Stay until `rsp_ready=1`, then go to IDLE.
- `req_ready` is all zeros outside IDLE.
- `rsp_data` and `rsp_id` are stable while `rsp_valid` is high and unaccepted.
- `mul_a`/`mul_b` hold their last values after the operation; they are not cleared.
- Requesters must not make `req_valid` depend on `req_ready`. A requester's data must stay stable while its `req_valid` is high.
- Reset mid-operation: the in-flight operation is discarded with no response. The FSM returns to IDLE and `last=NREQ-1`, so requester 0 has highest priority.
- Simultaneous requests: exactly one is granted per IDLE cycle. Losers keep `req_valid` asserted and are served in later rounds. No requester waits more than NREQ-1 grants.
- Pointer wrap: with `last=NREQ-1`, the search starts at index 0.

## Timing
- Reset values: `req_ready=0`, `mul_a=0`, `mul_b=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `busy=0`, state IDLE, `last=NREQ-1`.
- Transfer in cycle N (IDLE):
  - `mul_a`/`mul_b` valid from cycle N+1 (EXEC).
  - `rsp_valid` high from cycle N+2.
- With `rsp_ready` held high:
  - Response accepted in cycle N+2; back in IDLE at N+3.
  - Peak throughput is one operation per 3 cycles.
- The multiplier path gets one full clock cycle from the `mul_a`/`mul_b` register to the `rsp_data` register.
- `busy` is registered: high in cycles N+1 through the cycle of response acceptance.

## Test plan
- Single op: requester 1 sends a=0x29, b=0x10 with the real `ApproxModule`. Expect `req_ready=4'b0010` in cycle N, `rsp_valid` at N+2, `rsp_id=1`, `rsp_data=0x0290`. Mitchell is exact when one operand is a power of two.
- Zero short-circuit: requester 2 sends a=0x00, b=0xFF. Expect `rsp_data=0x0000`, `rsp_id=2`, latency 2 cycles.
- Round-robin: all four requesters valid continuously with `rsp_ready=1`.
  - Grant order after reset: 0,1,2,3,0.
  - Grants are spaced 3 cycles apart.
  - Each `rsp_id` matches its grant.
- Backpressure: hold `rsp_ready=0` for 5 cycles in RESP. Expect `rsp_valid`, `rsp_id` and `rsp_data` constant, `req_ready=0` throughout, and the next grant one cycle after acceptance.
- Reset mid-op: assert `rst_n=0` in EXEC. Expect all outputs at reset values immediately (asynchronous), no response, and the first grant after release going to requester 0.
- Exhaustive sweep: each requester runs all 65536 (a,b) pairs. Compare `rsp_data` against a reference `ApproxModule` instance, with zero cases forced to 0.
